sp_sram2: RTL and testbench
===========================

SP_SRAM2 -- requirements
Module: sp_sram2

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4: address bus width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16: word width; must be an integer multiple of BYTE_WIDTH.
REQ-003 SHALL have parameter BYTE_WIDTH, default 8: bits per write-enable lane.
REQ-004 SHALL have parameter DEPTH, default 2**ADDR_WIDTH: number of words; 1 <= DEPTH <= 2**ADDR_WIDTH.
REQ-005 SHALL have parameter RDW_MODE, default 0: write-cycle output policy; 0 = read-first, 1 = write-first, 2 = no-change.
REQ-006 SHALL have parameter READ_LATENCY, default 1: request-to-qout cycles; legal values 1 or 2.
REQ-007 SHALL have parameter INIT_ON_RESET, default 1: 1 = zero-fill the whole array after reset.
REQ-008 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-010 SHALL have port en, input, 1 bit: access request.
REQ-011 SHALL have port wr, input, 1 bit: 1 = write, 0 = read; qualified by en.
REQ-012 SHALL have port addr, input, ADDR_WIDTH bits: word address.
REQ-013 SHALL have port din, input, DATA_WIDTH bits: write data.
REQ-014 SHALL have port be, input, DATA_WIDTH/BYTE_WIDTH bits: byte-lane write enables; lane i covers din[i*BYTE_WIDTH +: BYTE_WIDTH].
REQ-015 SHALL have port qout, output, DATA_WIDTH bits: read data.
REQ-016 SHALL have port qvalid, output, 1 bit: qout carries the result of an access this cycle.
REQ-017 SHALL have port busy, output, 1 bit: initialisation in progress; requests are ignored.

Function
REQ-018 SHALL implement a two-state controller: INIT (busy=1) and READY (busy=0).
REQ-019 With INIT_ON_RESET=1, SHALL enter INIT on the cycle rst deasserts and write zero to address k on the k-th INIT cycle, k = 0..DEPTH-1, then enter READY; INIT lasts exactly DEPTH cycles.
REQ-020 With INIT_ON_RESET=0, SHALL enter READY directly; array contents are undefined until written.
REQ-021 In INIT, SHALL ignore en; no qvalid SHALL be produced by a request made during INIT.
REQ-022 In READY with en=1 and wr=1, SHALL update only the lanes with be[i]=1 at mem[addr]; be=0 leaves the word unchanged.
REQ-023 In READY with en=1 and wr=0, SHALL return mem[addr] on qout with qvalid=1 exactly READ_LATENCY cycles after the request edge.
REQ-024 On a write with RDW_MODE=0, SHALL return the pre-write word with qvalid=1 after READ_LATENCY cycles.
REQ-025 On a write with RDW_MODE=1, SHALL return the post-merge word with qvalid=1 after READ_LATENCY cycles.
REQ-026 On a write with RDW_MODE=2, SHALL hold qout and keep qvalid=0 for that request.
REQ-027 When no request completes in a cycle, SHALL hold qout at its previous value with qvalid=0; it SHALL never drive X.
REQ-028 For addr >= DEPTH, SHALL discard writes and return all-zero data with qvalid=1 on reads.
REQ-029 SHALL accept one request per cycle back-to-back at either latency; a read after a write to the same address SHALL see the written data.
REQ-030 With READ_LATENCY=2, the extra stage SHALL be a plain register: pipelined data and valid advance every cycle with no stall.

Reset
REQ-031 While rst=1: qout=0, qvalid=0, pipeline valid bits cleared, init counter=0, busy=INIT_ON_RESET; requests ignored.
REQ-032 rst SHALL NOT alter array contents except through the INIT sequence that follows it.
REQ-033 rst asserted mid-INIT SHALL restart INIT from address 0 after deassertion.
REQ-034 rst asserted with reads in flight SHALL cancel them; no qvalid SHALL appear after reset for a request made before it.

Verification
REQ-035 DEPTH=16, INIT_ON_RESET=1: release rst -> busy=1 for exactly 16 cycles; a read of every address then returns 0x0000.
REQ-036 Write 0xABCD with be=2'b01 to address 3 over 0xFFFF, then read address 3 -> qout=0xFFCD, qvalid=1 after READ_LATENCY cycles.
REQ-037 Address 5 holds 0x1111; write 0x2222 with be=2'b11 -> qout=0x1111 (mode 0), 0x2222 (mode 1), or held with qvalid=0 (mode 2).
REQ-038 READ_LATENCY=2, back-to-back reads of addresses 0,1,2 holding 0xA0,0xA1,0xA2 -> qvalid high for 3 consecutive cycles starting 2 cycles after the first request, with data 0xA0,0xA1,0xA2.
REQ-039 Assert rst on INIT cycle 7, then release -> busy=1 for a full 16 cycles; a read issued during busy produces no qvalid.
REQ-040 DEPTH=12: write to address 13 -> discarded; read address 13 -> qout=0, qvalid=1; addresses 0..11 unchanged.

Source files
------------

// File: rtl/sp_sram2.sv
// Single-port SRAM with byte-lane writes, a selectable read-during-write policy,
// 1- or 2-cycle read latency and an optional zero-fill sequence after reset.
module sp_sram2 #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int BYTE_WIDTH    = 8,
  parameter int DEPTH         = 2 ** ADDR_WIDTH,
  parameter int RDW_MODE      = 0,
  parameter int READ_LATENCY  = 1,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             wr,
  input  logic [ADDR_WIDTH-1:0]            addr,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be,
  output logic [DATA_WIDTH-1:0]            qout,
  output logic                             qvalid,
  output logic                             busy
);

  localparam int unsigned LANES = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    init_we;
  logic                    acc;
  logic                    in_range;
  logic                    wr_mem;
  logic [DATA_WIDTH-1:0]   old_word;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    resp_v;
  logic [DATA_WIDTH-1:0]   resp_data;
  logic                    v1_q, v1_d;
  logic [DATA_WIDTH-1:0]   d1_q, d1_d;

  // Controller: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (INIT_ON_RESET != 0) ? S_INIT : S_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controller: next state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
        state_d = S_READY;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ADDR_WIDTH'(1);
      end
    end
  end

  // Controller: outputs; rst gates every array and pipeline update
  always_comb begin
    busy    = (state_q == S_INIT);
    init_we = (state_q == S_INIT) && !rst;
    acc     = (state_q == S_READY) && en && !rst;
  end

  if (DEPTH == 2 ** ADDR_WIDTH) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (addr < ADDR_WIDTH'(DEPTH));
  end

  always_comb begin
    old_word = in_range ? mem_q[addr] : '0;
    merged   = old_word;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (be[i]) merged[i*BYTE_WIDTH +: BYTE_WIDTH] = din[i*BYTE_WIDTH +: BYTE_WIDTH];
    end
    wr_mem = acc && wr && in_range;
  end

  // Response for this cycle's request; out-of-range accesses answer with zero
  always_comb begin
    resp_v    = acc && (!wr || (RDW_MODE != 2));
    resp_data = old_word;
    if (wr && (RDW_MODE == 1)) resp_data = in_range ? merged : '0;
    v1_d = resp_v;
    d1_d = resp_v ? resp_data : d1_q;
  end

  always_ff @(posedge clk) begin
    if (init_we) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_mem) begin
      mem_q[addr] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= v1_d;
      d1_q <= d1_d;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  v2_q;
    logic [DATA_WIDTH-1:0] d2_q;
    // d1_q already holds between responses, so the second stage copies freely
    always_ff @(posedge clk) begin
      if (rst) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        d2_q <= d1_q;
      end
    end
    assign qout   = d2_q;
    assign qvalid = v2_q;
  end else begin : g_lat1
    assign qout   = d1_q;
    assign qvalid = v1_q;
  end

endmodule

// File: tb/tb_sp_sram2.sv
// Directed bench for sp_sram2: three configurations share one stimulus stream
// (read-first/lat1/16 words, write-first/lat2/16 words, no-change/lat1/12 words).
module tb_sp_sram2;

  logic        clk;
  logic        rst;
  logic        en;
  logic        wr;
  logic [3:0]  addr;
  logic [15:0] din;
  logic [1:0]  be;

  logic [15:0] q0, q1, q2;
  logic        v0, v1, v2;
  logic        b0, b1, b2;

  int checks = 0;
  int errors = 0;
  int n0, n2, nv;

  sp_sram2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(16),
             .RDW_MODE(0), .READ_LATENCY(1), .INIT_ON_RESET(1)) u0 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din), .be(be),
    .qout(q0), .qvalid(v0), .busy(b0));

  sp_sram2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(16),
             .RDW_MODE(1), .READ_LATENCY(2), .INIT_ON_RESET(1)) u1 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din), .be(be),
    .qout(q1), .qvalid(v1), .busy(b1));

  sp_sram2 #(.ADDR_WIDTH(4), .DATA_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(12),
             .RDW_MODE(2), .READ_LATENCY(1), .INIT_ON_RESET(1)) u2 (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .din(din), .be(be),
    .qout(q2), .qvalid(v2), .busy(b2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic req(input logic e, input logic w, input logic [3:0] a,
                     input logic [15:0] d, input logic [1:0] b);
    en = e; wr = w; addr = a; din = d; be = b;
  endtask

  task automatic chk(input string tag, input logic [15:0] q, input logic v,
                     input logic [15:0] eq, input logic ev);
    checks++;
    assert ({q, v} === {eq, ev}) else begin
      errors++;
      $error("FAIL %s: qout=%h qvalid=%b, expected qout=%h qvalid=%b", tag, q, v, eq, ev);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Called at the negedge where rst has just dropped; read requests are
  // issued during the first 12 INIT cycles and must never produce qvalid.
  task automatic init_window(output int c0, output int c2, output int cv);
    c0 = 0; c2 = 0; cv = 0;
    for (int i = 0; i < 20; i++) begin
      if (b0 === 1'b1) c0++;
      if (b2 === 1'b1) c2++;
      if (v0 !== 1'b0) cv++;
      if (v1 !== 1'b0) cv++;
      if (v2 !== 1'b0) cv++;
      req(i <= 11, 1'b0, 4'd3, 16'h0, 2'b00);
      tick();
    end
  endtask

  initial begin
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    rst = 1'b1;
    repeat (3) tick();

    chk("rst_u0", q0, v0, 16'h0, 1'b0);
    chk("rst_u1", q1, v1, 16'h0, 1'b0);
    chk("rst_u2", q2, v2, 16'h0, 1'b0);
    chki("rst_busy", int'(b0) + int'(b1) + int'(b2), 3);

    rst = 1'b0;
    init_window(n0, n2, nv);
    chki("init_len_u0", n0, 16);
    chki("init_len_u2", n2, 12);
    chki("init_noqv", nv, 0);

    // Zero-fill: read every address back to back
    for (int k = 0; k < 18; k++) begin
      if (k >= 1) begin
        chk("zero_u0", q0, v0, 16'h0, k <= 16);
        chk("zero_u2", q2, v2, 16'h0, k <= 16);
      end
      if (k >= 2) chk("zero_u1", q1, v1, 16'h0, 1'b1);
      if (k < 16) req(1'b1, 1'b0, 4'(k), 16'h0, 2'b00);
      else        req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
      tick();
    end

    // Byte-lane merge at address 3
    req(1'b1, 1'b1, 4'd3, 16'hFFFF, 2'b11); tick();
    chk("bl_b_u0", q0, v0, 16'h0000, 1'b1);
    chk("bl_b_u1", q1, v1, 16'h0000, 1'b0);
    chk("bl_b_u2", q2, v2, 16'h0000, 1'b0);
    req(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b01); tick();
    chk("bl_c_u0", q0, v0, 16'hFFFF, 1'b1);
    chk("bl_c_u1", q1, v1, 16'hFFFF, 1'b1);
    chk("bl_c_u2", q2, v2, 16'h0000, 1'b0);
    req(1'b1, 1'b0, 4'd3, 16'h0, 2'b00); tick();
    chk("bl_d_u0", q0, v0, 16'hFFCD, 1'b1);
    chk("bl_d_u1", q1, v1, 16'hFFCD, 1'b1);
    chk("bl_d_u2", q2, v2, 16'hFFCD, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("bl_e_u0", q0, v0, 16'hFFCD, 1'b0);
    chk("bl_e_u1", q1, v1, 16'hFFCD, 1'b1);
    chk("bl_e_u2", q2, v2, 16'hFFCD, 1'b0);
    tick();
    chk("bl_f_u1", q1, v1, 16'hFFCD, 1'b0);

    // Read-during-write policy at address 5
    req(1'b1, 1'b1, 4'd5, 16'h1111, 2'b11); tick();
    chk("rdw_g_u0", q0, v0, 16'h0000, 1'b1);
    chk("rdw_g_u1", q1, v1, 16'hFFCD, 1'b0);
    chk("rdw_g_u2", q2, v2, 16'hFFCD, 1'b0);
    req(1'b1, 1'b1, 4'd5, 16'h2222, 2'b11); tick();
    chk("rdw_h_u0", q0, v0, 16'h1111, 1'b1);
    chk("rdw_h_u1", q1, v1, 16'h1111, 1'b1);
    chk("rdw_h_u2", q2, v2, 16'hFFCD, 1'b0);
    req(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); tick();
    chk("rdw_i_u0", q0, v0, 16'h2222, 1'b1);
    chk("rdw_i_u1", q1, v1, 16'h2222, 1'b1);
    chk("rdw_i_u2", q2, v2, 16'h2222, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("rdw_j_u0", q0, v0, 16'h2222, 1'b0);
    chk("rdw_j_u1", q1, v1, 16'h2222, 1'b1);
    chk("rdw_j_u2", q2, v2, 16'h2222, 1'b0);

    // Address range: 11 is the last word of u2, 12 and 13 lie beyond it
    req(1'b1, 1'b1, 4'd11, 16'h5A5A, 2'b11); tick();
    chk("rng_k_u0", q0, v0, 16'h0000, 1'b1);
    chk("rng_k_u1", q1, v1, 16'h2222, 1'b0);
    req(1'b1, 1'b1, 4'd13, 16'h1357, 2'b11); tick();
    chk("rng_l_u0", q0, v0, 16'h0000, 1'b1);
    chk("rng_l_u1", q1, v1, 16'h5A5A, 1'b1);
    chk("rng_l_u2", q2, v2, 16'h2222, 1'b0);
    req(1'b1, 1'b0, 4'd13, 16'h0, 2'b00); tick();
    chk("rng_m_u0", q0, v0, 16'h1357, 1'b1);
    chk("rng_m_u1", q1, v1, 16'h1357, 1'b1);
    chk("rng_m_u2", q2, v2, 16'h0000, 1'b1);
    req(1'b1, 1'b0, 4'd11, 16'h0, 2'b00); tick();
    chk("rng_n_u0", q0, v0, 16'h5A5A, 1'b1);
    chk("rng_n_u1", q1, v1, 16'h1357, 1'b1);
    chk("rng_n_u2", q2, v2, 16'h5A5A, 1'b1);
    req(1'b1, 1'b0, 4'd12, 16'h0, 2'b00); tick();
    chk("rng_o_u0", q0, v0, 16'h0000, 1'b1);
    chk("rng_o_u1", q1, v1, 16'h5A5A, 1'b1);
    chk("rng_o_u2", q2, v2, 16'h0000, 1'b1);
    req(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); tick();
    chk("rng_p_u0", q0, v0, 16'h2222, 1'b1);
    chk("rng_p_u1", q1, v1, 16'h0000, 1'b1);
    chk("rng_p_u2", q2, v2, 16'h2222, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("rng_q_u0", q0, v0, 16'h2222, 1'b0);
    chk("rng_q_u1", q1, v1, 16'h2222, 1'b1);

    // be=00 leaves the word alone; be=10 touches only the upper lane
    req(1'b1, 1'b1, 4'd5, 16'h9999, 2'b00); tick();
    chk("be_r_u0", q0, v0, 16'h2222, 1'b1);
    chk("be_r_u1", q1, v1, 16'h2222, 1'b0);
    chk("be_r_u2", q2, v2, 16'h2222, 1'b0);
    req(1'b1, 1'b1, 4'd5, 16'h77AB, 2'b10); tick();
    chk("be_s_u0", q0, v0, 16'h2222, 1'b1);
    chk("be_s_u1", q1, v1, 16'h2222, 1'b1);
    req(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); tick();
    chk("be_t_u0", q0, v0, 16'h7722, 1'b1);
    chk("be_t_u1", q1, v1, 16'h7722, 1'b1);
    chk("be_t_u2", q2, v2, 16'h7722, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("be_u_u1", q1, v1, 16'h7722, 1'b1);

    // Back-to-back reads through the two-stage pipeline
    req(1'b1, 1'b1, 4'd0, 16'h00A0, 2'b11); tick();
    req(1'b1, 1'b1, 4'd1, 16'h00A1, 2'b11); tick();
    req(1'b1, 1'b1, 4'd2, 16'h00A2, 2'b11); tick();
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    tick();
    req(1'b1, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("b2b_1_u1", q1, v1, 16'h00A2, 1'b0);
    chk("b2b_1_u0", q0, v0, 16'h00A0, 1'b1);
    req(1'b1, 1'b0, 4'd1, 16'h0, 2'b00); tick();
    chk("b2b_2_u1", q1, v1, 16'h00A0, 1'b1);
    chk("b2b_2_u0", q0, v0, 16'h00A1, 1'b1);
    req(1'b1, 1'b0, 4'd2, 16'h0, 2'b00); tick();
    chk("b2b_3_u1", q1, v1, 16'h00A1, 1'b1);
    chk("b2b_3_u0", q0, v0, 16'h00A2, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("b2b_4_u1", q1, v1, 16'h00A2, 1'b1);
    chk("b2b_4_u0", q0, v0, 16'h00A2, 1'b0);
    tick();
    chk("b2b_5_u1", q1, v1, 16'h00A2, 1'b0);

    // Reset with a read in flight, then reset again on INIT cycle 7
    req(1'b1, 1'b0, 4'd1, 16'h0, 2'b00); tick();
    chk("fl_u0", q0, v0, 16'h00A1, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    rst = 1'b1; tick();
    chk("fl_rst_u0", q0, v0, 16'h0, 1'b0);
    chk("fl_rst_u1", q1, v1, 16'h0, 1'b0);
    chk("fl_rst_u2", q2, v2, 16'h0, 1'b0);
    rst = 1'b0;
    repeat (7) tick();
    chki("mid_busy_pre", int'(b0) + int'(b2), 2);
    rst = 1'b1; tick();
    chki("mid_busy_rst", int'(b0) + int'(b1) + int'(b2), 3);
    rst = 1'b0;
    init_window(n0, n2, nv);
    chki("reinit_len_u0", n0, 16);
    chki("reinit_len_u2", n2, 12);
    chki("reinit_noqv", nv, 0);

    req(1'b1, 1'b0, 4'd3, 16'h0, 2'b00); tick();
    chk("post_3_u0", q0, v0, 16'h0, 1'b1);
    chk("post_3_u2", q2, v2, 16'h0, 1'b1);
    req(1'b1, 1'b0, 4'd5, 16'h0, 2'b00); tick();
    chk("post_5_u0", q0, v0, 16'h0, 1'b1);
    chk("post_3_u1", q1, v1, 16'h0, 1'b1);
    req(1'b0, 1'b0, 4'd0, 16'h0, 2'b00); tick();
    chk("post_5_u1", q1, v1, 16'h0, 1'b1);
    chk("post_idle_u0", q0, v0, 16'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
